// File: rtl/nv_nvdla_reset_seq.sv
// Reset request sequencer ahead of the NVDLA reset synchronizer: drain, hold reset low, release, await feedback.
// Optional drain timeout is built only when NVDLA_RESET_SEQ_TIMEOUT_EN is defined.
module nv_nvdla_reset_seq #(
   parameter int ASSERT_CYCLES = 16,
   parameter int DRAIN_TIMEOUT = 1024
) (
   input  logic nvdla_clk,
   input  logic dla_reset,
   input  logic sw_reset_req,
   input  logic engine_idle,
   input  logic synced_rstn_fb,
   output logic drain_req,
   output logic dla_reset_rstn,
   output logic reset_busy,
   output logic reset_done,
   output logic drain_timeout
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_DRAIN   = 2'd1;
   localparam logic [1:0] S_ASSERT  = 2'd2;
   localparam logic [1:0] S_RELEASE = 2'd3;

   localparam int HOLD_W = (ASSERT_CYCLES > 1) ? $clog2(ASSERT_CYCLES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(ASSERT_CYCLES - 1);

   logic [1:0]        r_state;
   logic [1:0]        w_state_nxt;
   logic [HOLD_W-1:0] r_hold_cnt;
   logic [HOLD_W-1:0] w_hold_nxt;
   logic              r_drain_req;
   logic              r_rstn;
   logic              r_busy;
   logic              r_done;
   logic              w_done_nxt;
   logic              r_drain_to;
   logic              w_drain_to_nxt;

`ifdef NVDLA_RESET_SEQ_TIMEOUT_EN
   localparam int DRAIN_W = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
   localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_TIMEOUT - 1);

   logic [DRAIN_W-1:0] r_drain_cnt;
   logic [DRAIN_W-1:0] w_drain_nxt;
`else
   // DRAIN_TIMEOUT has no effect when the timeout feature is not built.
   logic w_unused_timeout;
   assign w_unused_timeout = |DRAIN_TIMEOUT;
`endif

   always_comb begin
      w_state_nxt    = r_state;
      w_hold_nxt     = r_hold_cnt;
      w_done_nxt     = 1'b0;
      w_drain_to_nxt = r_drain_to;
`ifdef NVDLA_RESET_SEQ_TIMEOUT_EN
      w_drain_nxt    = r_drain_cnt;
`endif
      case (r_state)
         S_IDLE: begin
            if (sw_reset_req) begin
               w_state_nxt    = S_DRAIN;
               w_drain_to_nxt = 1'b0;
`ifdef NVDLA_RESET_SEQ_TIMEOUT_EN
               w_drain_nxt    = '0;
`endif
            end
         end
         S_DRAIN: begin
            // Idle wins over a timeout landing in the same cycle.
            if (engine_idle) begin
               w_state_nxt = S_ASSERT;
               w_hold_nxt  = '0;
            end
`ifdef NVDLA_RESET_SEQ_TIMEOUT_EN
            else if (r_drain_cnt == DRAIN_LAST) begin
               w_state_nxt    = S_ASSERT;
               w_hold_nxt     = '0;
               w_drain_to_nxt = 1'b1;
            end else begin
               w_drain_nxt = r_drain_cnt + 1'b1;
            end
`endif
         end
         S_ASSERT: begin
            if (r_hold_cnt == HOLD_LAST) begin
               w_state_nxt = S_RELEASE;
            end else begin
               w_hold_nxt = r_hold_cnt + 1'b1;
            end
         end
         S_RELEASE: begin
            if (synced_rstn_fb) begin
               w_state_nxt = S_IDLE;
               w_done_nxt  = 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_ASSERT;
            w_hold_nxt  = '0;
         end
      endcase
   end

   // Outputs are registered from the next state so they line up with the state register.
   always_ff @(posedge nvdla_clk or posedge dla_reset) begin
      if (dla_reset) begin
         r_state     <= S_ASSERT;
         r_hold_cnt  <= '0;
         r_drain_req <= 1'b0;
         r_rstn      <= 1'b0;
         r_busy      <= 1'b1;
         r_done      <= 1'b0;
         r_drain_to  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_hold_cnt  <= w_hold_nxt;
         r_drain_req <= (w_state_nxt == S_DRAIN);
         r_rstn      <= (w_state_nxt != S_ASSERT);
         r_busy      <= (w_state_nxt != S_IDLE);
         r_done      <= w_done_nxt;
         r_drain_to  <= w_drain_to_nxt;
      end
   end

`ifdef NVDLA_RESET_SEQ_TIMEOUT_EN
   always_ff @(posedge nvdla_clk or posedge dla_reset) begin
      if (dla_reset) begin
         r_drain_cnt <= '0;
      end else begin
         r_drain_cnt <= w_drain_nxt;
      end
   end

   assign drain_timeout = r_drain_to;
`else
   assign drain_timeout = 1'b0;
`endif

   assign drain_req      = r_drain_req;
   assign dla_reset_rstn = r_rstn;
   assign reset_busy     = r_busy;
   assign reset_done     = r_done;

endmodule

// File: tb/tb_nv_nvdla_reset_seq.sv
// Directed bench for nv_nvdla_reset_seq: power-on, software reset, drain wait/timeout, busy requests, mid-sequence reset.
module tb_nv_nvdla_reset_seq;

   logic clk = 1'b0;
   logic dla_reset = 1'b0;
   logic sw_reset_req = 1'b0;
   logic engine_idle = 1'b0;
   logic synced_rstn_fb;
   logic drain_req, dla_reset_rstn, reset_busy, reset_done, drain_timeout;
   logic [2:0] fb_sr;
   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   // Downstream synchronizer model: feedback follows rstn three edges later.
   always_ff @(posedge clk or posedge dla_reset) begin
      if (dla_reset) fb_sr <= 3'b000;
      else           fb_sr <= {fb_sr[1:0], dla_reset_rstn};
   end
   assign synced_rstn_fb = fb_sr[2];

   nv_nvdla_reset_seq #(.ASSERT_CYCLES(16), .DRAIN_TIMEOUT(8)) dut (
      .nvdla_clk(clk),
      .dla_reset(dla_reset),
      .sw_reset_req(sw_reset_req),
      .engine_idle(engine_idle),
      .synced_rstn_fb(synced_rstn_fb),
      .drain_req(drain_req),
      .dla_reset_rstn(dla_reset_rstn),
      .reset_busy(reset_busy),
      .reset_done(reset_done),
      .drain_timeout(drain_timeout)
   );

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic e_drn, input logic e_rstn,
                          input logic e_busy, input logic e_done, input logic e_to);
      chk({tag, ".drain_req"}, drain_req, e_drn);
      chk({tag, ".rstn"}, dla_reset_rstn, e_rstn);
      chk({tag, ".busy"}, reset_busy, e_busy);
      chk({tag, ".done"}, reset_done, e_done);
      chk({tag, ".timeout"}, drain_timeout, e_to);
   endtask

   task automatic cyc(input string tag, input logic e_drn, input logic e_rstn,
                      input logic e_busy, input logic e_done, input logic e_to);
      @(posedge clk);
      #1;
      chk_all(tag, e_drn, e_rstn, e_busy, e_done, e_to);
   endtask

   task automatic hold(input string tag, input int n, input logic e_to);
      for (int i = 0; i < n; i++) cyc(tag, 1'b0, 1'b0, 1'b1, 1'b0, e_to);
   endtask

   // rstn rise cycle plus three feedback cycles, then the done pulse and a quiet idle cycle.
   task automatic tail(input string tag, input logic e_to, input logic req_at_done);
      for (int i = 0; i < 4; i++) cyc({tag, ".rel"}, 1'b0, 1'b1, 1'b1, 1'b0, e_to);
      sw_reset_req = req_at_done;
      cyc({tag, ".done"}, 1'b0, 1'b1, 1'b0, 1'b1, e_to);
      sw_reset_req = 1'b0;
      cyc({tag, ".idle"}, 1'b0, 1'b1, 1'b0, 1'b0, e_to);
   endtask

   task automatic sw_start(input string tag, input logic idle);
      engine_idle = idle;
      sw_reset_req = 1'b1;
      cyc({tag, ".drain"}, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      sw_reset_req = 1'b0;
   endtask

   initial begin
      // Power-on
      #1 dla_reset = 1'b1;
      #1 chk_all("por_async", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) cyc("por_hold", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      dla_reset = 1'b0;
      hold("por_low", 15, 1'b0);
      tail("por", 1'b0, 1'b0);
      cyc("por_quiet", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

      // Software reset, engine already idle; second request during ASSERT and one at the done edge are ignored
      sw_start("sw", 1'b1);
      hold("sw_low", 5, 1'b0);
      sw_reset_req = 1'b1;
      hold("sw_busyreq", 1, 1'b0);
      sw_reset_req = 1'b0;
      hold("sw_low2", 10, 1'b0);
      tail("sw", 1'b0, 1'b1);
      cyc("sw_noreq", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

`ifdef NVDLA_RESET_SEQ_TIMEOUT_EN
      // Drain timeout after 8 drain cycles, sticky until the next request
      sw_start("to", 1'b0);
      for (int i = 0; i < 7; i++) cyc("to_drain", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      hold("to_low", 16, 1'b1);
      tail("to", 1'b1, 1'b0);
      cyc("to_sticky", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      // Idle arriving on the last drain cycle takes priority over timeout
      sw_start("tie", 1'b0);
      for (int i = 0; i < 7; i++) cyc("tie_drain", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      engine_idle = 1'b1;
      hold("tie_low", 16, 1'b0);
      tail("tie", 1'b0, 1'b0);
`else
      // Without the timeout, drain waits indefinitely for engine_idle
      sw_start("wait", 1'b0);
      for (int i = 0; i < 99; i++) cyc("wait_drain", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      engine_idle = 1'b1;
      hold("wait_low", 16, 1'b0);
      tail("wait", 1'b0, 1'b0);
`endif

      // Asynchronous reset during RELEASE restarts a full hold
      sw_start("mid", 1'b1);
      hold("mid_low", 16, 1'b0);
      cyc("mid_rel", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      cyc("mid_rel", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      dla_reset = 1'b1;
      #1 chk_all("mid_async", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) cyc("mid_hold", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      dla_reset = 1'b0;
      hold("mid_low2", 15, 1'b0);
      tail("mid", 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
